// File: rtl/qq_arb.sv
// qq_arb: round-robin arbiter that serialises client enqueue/dequeue requests
// onto a single shared QuickQ instance, with local full/empty rejection and a
// completion watchdog. All outputs decode from registered state only.
module qq_arb #(
    parameter int unsigned N   = 4,
    parameter int unsigned W   = 8,
    parameter int unsigned TMO = 15
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req_enq,
    input  logic [N-1:0]   req_deq,
    input  logic [N*W-1:0] req_key,
    output logic [N-1:0]   gnt,
    output logic [W-1:0]   rsp_key,
    output logic           rsp_err,
    output logic           busy,
    output logic           q_enq,
    output logic           q_deq,
    output logic [W-1:0]   q_key,
    input  logic           q_enq_done,
    input  logic           q_deq_done,
    input  logic [W-1:0]   q_dout,
    input  logic           q_full,
    input  logic           q_empty
);

    localparam int unsigned IW = $clog2(N);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StResp
    } state_e;

    state_e         state_q, state_d;
    logic [IW-1:0]  last_q, last_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic           op_q, op_d;       // 1 = dequeue
    logic [W-1:0]   key_q, key_d;
    logic [7:0]     cnt_q, cnt_d;
    logic           err_q, err_d;
    logic [W-1:0]   rkey_q, rkey_d;

    logic [N-1:0]   pend;
    logic           pend_vld;
    logic [IW-1:0]  pend_idx;
    logic [W-1:0]   keys [N];
    logic           done_match;

    assign pend       = req_enq | req_deq;
    assign done_match = op_q ? q_deq_done : q_enq_done;

    // Split the flat key bus into per-client slices.
    always_comb begin
        for (int unsigned i = 0; i < N; i++) begin
            keys[i] = req_key[i*W +: W];
        end
    end

    // Round-robin search: first pending client after the last one served, with wrap.
    always_comb begin
        logic [IW-1:0] cand;
        pend_vld = 1'b0;
        pend_idx = '0;
        cand     = last_q;
        for (int unsigned k = 0; k < N; k++) begin
            cand = (cand == IW'(N - 1)) ? '0 : cand + 1'b1;
            if (!pend_vld && pend[cand]) begin
                pend_vld = 1'b1;
                pend_idx = cand;
            end
        end
    end

    // Next-state logic for the sequencer.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        idx_d   = idx_q;
        op_d    = op_q;
        key_d   = key_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        rkey_d  = rkey_q;
        unique case (state_q)
            StIdle: begin
                if (pend_vld) begin
                    idx_d  = pend_idx;
                    // Enqueue wins when a client asks for both; dequeue stays pending.
                    op_d   = !req_enq[pend_idx];
                    key_d  = keys[pend_idx];
                    rkey_d = '0;
                    if (req_enq[pend_idx] ? q_full : q_empty) begin
                        err_d   = 1'b1;
                        state_d = StResp;
                    end else begin
                        err_d   = 1'b0;
                        state_d = StIssue;
                    end
                end
            end
            StIssue: begin
                cnt_d = '0;
                if (done_match) begin
                    if (op_q) rkey_d = q_dout;
                    err_d   = 1'b0;
                    state_d = StResp;
                end else begin
                    state_d = StWait;
                end
            end
            StWait: begin
                cnt_d = cnt_q + 8'd1;
                if (done_match) begin
                    if (op_q) rkey_d = q_dout;
                    err_d   = 1'b0;
                    state_d = StResp;
                end else if (cnt_q == 8'(TMO - 1)) begin
                    // Completion considered lost after TMO wait cycles.
                    err_d   = 1'b1;
                    rkey_d  = '0;
                    state_d = StResp;
                end
            end
            StResp: begin
                last_d  = idx_q;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            last_q  <= IW'(N - 1);
            idx_q   <= '0;
            op_q    <= 1'b0;
            key_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            rkey_q  <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            idx_q   <= idx_d;
            op_q    <= op_d;
            key_q   <= key_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            rkey_q  <= rkey_d;
        end
    end

    // Output decode from registered state.
    always_comb begin
        gnt     = '0;
        rsp_key = '0;
        rsp_err = 1'b0;
        if (state_q == StResp) begin
            gnt[idx_q] = 1'b1;
            rsp_key    = rkey_q;
            rsp_err    = err_q;
        end
        busy  = (state_q != StIdle);
        q_enq = (state_q == StIssue) && !op_q;
        q_deq = (state_q == StIssue) && op_q;
        q_key = key_q;
    end

endmodule

// File: tb/tb_qq_arb.sv
// Self-checking bench for qq_arb: directed vectors, hand sequences and a
// randomized run against a transaction-level reference with a queue model.
module tb_qq_arb;
    localparam int unsigned N   = 4;
    localparam int unsigned W   = 8;
    localparam int unsigned TMO = 15;
    localparam int          CAP = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req_enq = '0;
    logic [N-1:0]   req_deq = '0;
    logic [N*W-1:0] req_key = '0;
    logic [N-1:0]   gnt;
    logic [W-1:0]   rsp_key;
    logic           rsp_err;
    logic           busy;
    logic           q_enq;
    logic           q_deq;
    logic [W-1:0]   q_key;
    logic           q_enq_done = 1'b0;
    logic           q_deq_done = 1'b0;
    logic [W-1:0]   q_dout = '0;
    logic           q_full = 1'b0;
    logic           q_empty = 1'b1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    qq_arb #(.N(N), .W(W), .TMO(TMO)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_enq    (req_enq),
        .req_deq    (req_deq),
        .req_key    (req_key),
        .gnt        (gnt),
        .rsp_key    (rsp_key),
        .rsp_err    (rsp_err),
        .busy       (busy),
        .q_enq      (q_enq),
        .q_deq      (q_deq),
        .q_key      (q_key),
        .q_enq_done (q_enq_done),
        .q_deq_done (q_deq_done),
        .q_dout     (q_dout),
        .q_full     (q_full),
        .q_empty    (q_empty)
    );

    typedef struct {
        int             cl;
        bit             deq;
        logic [W-1:0]   key;
        bit             full;
        bit             empty;
        int             dly;    // cycles from strobe to done; 99 = never
        logic [W-1:0]   dout;
        logic [N-1:0]   egnt;
        bit             eerr;
        logic [W-1:0]   ekey;
        int             elat;   // cycles from request to gnt
        int             estb;   // number of queue strobes
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic set_key(input int c, input logic [W-1:0] k);
        req_key[c*W +: W] = k;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst        = 1'b1;
        req_enq    = '0;
        req_deq    = '0;
        q_enq_done = 1'b0;
        q_deq_done = 1'b0;
        q_dout     = '0;
        q_full     = 1'b0;
        q_empty    = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Act as the queue for one operation: answer the strobe after dly cycles,
    // then check the grant and drop the served request.
    task automatic serve(input string nm, input bit exp_deq, input int dly,
                         input logic [W-1:0] dout, input logic [N-1:0] egnt,
                         input logic eerr, input logic [W-1:0] ekey, input int elat,
                         input int estb, input logic [W-1:0] eqkey);
        int stb_at = -1;
        int nstb   = 0;
        bit got    = 1'b0;
        for (int n = 1; n <= 40 && !got; n++) begin
            @(negedge clk);
            if (q_enq || q_deq) begin
                nstb++;
                stb_at = n;
                chk({nm, "_op"}, 32'(q_deq), 32'(exp_deq));
                chk({nm, "_qkey"}, 32'(q_key), 32'(eqkey));
            end
            if (gnt != '0) begin
                got = 1'b1;
                chk({nm, "_gnt"}, 32'(gnt), 32'(egnt));
                chk({nm, "_err"}, 32'(rsp_err), 32'(eerr));
                chk({nm, "_rkey"}, 32'(rsp_key), 32'(ekey));
                chk({nm, "_lat"}, 32'(n), 32'(elat));
                chk({nm, "_nstb"}, 32'(nstb), 32'(estb));
                if (exp_deq) req_deq = req_deq & ~gnt;
                else         req_enq = req_enq & ~gnt;
            end
            if (exp_deq) q_deq_done = (stb_at > 0) && (n == stb_at + dly);
            else         q_enq_done = (stb_at > 0) && (n == stb_at + dly);
            q_dout = ((stb_at > 0) && (n == stb_at + dly)) ? dout : '0;
        end
        if (!got) chk({nm, "_no_gnt"}, 32'd0, 32'd1);
        if (exp_deq) q_deq_done = 1'b0;
        else         q_enq_done = 1'b0;
    endtask

    // Randomized run: clients raise requests at random, the bench plays a
    // CAP-entry min-priority queue with random completion delays, and every
    // cycle's outputs are predicted from the transaction schedule.
    task automatic random_phase(input int ncyc);
        logic [W-1:0] mq[$];
        int           last = N - 1;
        bit           act  = 1'b0;
        int           sel = 0, stb = -10, dn = -10, gc = -10, cl = 0;
        bit           odeq = 1'b0, err = 1'b0, rej = 1'b0;
        logic [W-1:0] okey = '0, rkey = '0;
        logic [N-1:0] justg, pend, eg;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            eg = '0;
            if (act && c == gc) eg[cl] = 1'b1;
            chk("rnd_gnt", 32'(gnt), 32'(eg));
            chk("rnd_err", 32'(rsp_err), 32'((act && c == gc) ? err : 1'b0));
            chk("rnd_rkey", 32'(rsp_key), 32'((act && c == gc) ? rkey : '0));
            chk("rnd_busy", 32'(busy), 32'(act && c > sel && c <= gc));
            chk("rnd_q_enq", 32'(q_enq), 32'(act && !rej && c == stb && !odeq));
            chk("rnd_q_deq", 32'(q_deq), 32'(act && !rej && c == stb && odeq));
            if (act && !rej && c == stb) chk("rnd_q_key", 32'(q_key), 32'(okey));

            justg = '0;
            if (act && c == gc) begin
                if (odeq) req_deq[cl] = 1'b0;
                else      req_enq[cl] = 1'b0;
                justg[cl] = 1'b1;
            end

            q_enq_done = 1'b0;
            q_deq_done = 1'b0;
            q_dout     = W'($urandom);
            if (act && !rej && c == dn) begin
                if (odeq) begin
                    int mi = 0;
                    for (int j = 1; j < mq.size(); j++) if (mq[j] < mq[mi]) mi = j;
                    rkey = mq[mi];
                    mq.delete(mi);
                    q_dout     = rkey;
                    q_deq_done = 1'b1;
                end else begin
                    mq.push_back(okey);
                    q_enq_done = 1'b1;
                end
                q_full  = (mq.size() == CAP);
                q_empty = (mq.size() == 0);
            end else if ($urandom_range(3) == 0) begin
                // Stray completion: only the non-matching kind while an op is in flight.
                if (act && c <= gc) begin
                    if (odeq) q_enq_done = 1'b1;
                    else      q_deq_done = 1'b1;
                end else if ($urandom_range(1) == 0) begin
                    q_enq_done = 1'b1;
                end else begin
                    q_deq_done = 1'b1;
                end
            end

            for (int i = 0; i < N; i++) begin
                if (!req_enq[i] && !req_deq[i] && !justg[i] && $urandom_range(3) == 0) begin
                    int k = $urandom_range(3);
                    set_key(i, W'($urandom));
                    req_enq[i] = (k != 2);
                    req_deq[i] = (k >= 2);
                end
            end

            if (!act || c > gc) begin
                pend = req_enq | req_deq;
                if (pend != '0) begin
                    for (int k = 1; k <= N; k++) begin
                        if (pend[(last + k) % N]) begin
                            cl = (last + k) % N;
                            break;
                        end
                    end
                    act  = 1'b1;
                    sel  = c;
                    odeq = !req_enq[cl];
                    okey = req_key[cl*W +: W];
                    rkey = '0;
                    rej  = odeq ? q_empty : q_full;
                    if (rej) begin
                        err = 1'b1;
                        gc  = c + 1;
                        stb = -10;
                        dn  = -10;
                    end else begin
                        int r = $urandom_range(9);
                        stb = c + 1;
                        if (r == 0) begin
                            dn  = -10;
                            gc  = stb + TMO + 1;
                            err = 1'b1;
                        end else begin
                            int d = (r == 1) ? TMO : $urandom_range(3);
                            dn  = stb + d;
                            gc  = dn + 1;
                            err = 1'b0;
                        end
                    end
                    last = cl;
                end
            end
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[9];
        int   order[$];
        logic [N-1:0] rer;
        bit   seen;

        vt[0] = '{2, 1'b1, 8'h11, 1'b0, 1'b1, 0,  8'h00, 4'b0100, 1'b1, 8'h00, 1,  0};
        vt[1] = '{1, 1'b1, 8'h22, 1'b0, 1'b0, 3,  8'hA5, 4'b0010, 1'b0, 8'hA5, 5,  1};
        vt[2] = '{0, 1'b0, 8'h3C, 1'b0, 1'b0, 0,  8'h00, 4'b0001, 1'b0, 8'h00, 2,  1};
        vt[3] = '{3, 1'b0, 8'h44, 1'b1, 1'b0, 0,  8'h00, 4'b1000, 1'b1, 8'h00, 1,  0};
        vt[4] = '{1, 1'b0, 8'h55, 1'b0, 1'b0, 99, 8'h00, 4'b0010, 1'b1, 8'h00, 17, 1};
        vt[5] = '{2, 1'b1, 8'h66, 1'b0, 1'b0, 99, 8'hEE, 4'b0100, 1'b1, 8'h00, 17, 1};
        vt[6] = '{3, 1'b1, 8'h77, 1'b0, 1'b0, 15, 8'h5A, 4'b1000, 1'b0, 8'h5A, 17, 1};
        vt[7] = '{0, 1'b0, 8'h88, 1'b0, 1'b1, 1,  8'h00, 4'b0001, 1'b0, 8'h00, 3,  1};
        vt[8] = '{1, 1'b1, 8'h9A, 1'b1, 1'b0, 0,  8'hC3, 4'b0010, 1'b0, 8'hC3, 2,  1};

        // Reset held with client 0 already requesting.
        req_enq = 4'b0001;
        set_key(0, 8'h3C);
        q_full  = 1'b0;
        q_empty = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("rst_q_enq", 32'(q_enq), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_gnt", 32'(gnt), 32'd0);
        end
        chk("rst_q_key", 32'(q_key), 32'd0);
        chk("rst_rsp", 32'({rsp_err, rsp_key}), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("a_q_enq", 32'(q_enq), 32'd1);
        chk("a_q_key", 32'(q_key), 32'h3C);
        @(negedge clk);
        chk("a_gnt_early", 32'(gnt), 32'd0);
        @(negedge clk);
        q_enq_done = 1'b1;
        @(negedge clk);
        chk("a_gnt", 32'(gnt), 32'b0001);
        chk("a_err", 32'(rsp_err), 32'd0);
        q_enq_done = 1'b0;
        req_enq    = '0;

        // Directed single-client vectors; the non-matching done is held high throughout.
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            q_full  = vt[i].full;
            q_empty = vt[i].empty;
            set_key(vt[i].cl, vt[i].key);
            if (vt[i].deq) begin
                req_deq[vt[i].cl] = 1'b1;
                q_enq_done        = 1'b1;
            end else begin
                req_enq[vt[i].cl] = 1'b1;
                q_deq_done        = 1'b1;
            end
            serve($sformatf("vec%0d", i), vt[i].deq, vt[i].dly, vt[i].dout, vt[i].egnt,
                  vt[i].eerr, vt[i].ekey, vt[i].elat, vt[i].estb, vt[i].key);
            q_enq_done = 1'b0;
            q_deq_done = 1'b0;
            @(negedge clk);
            chk($sformatf("vec%0d_idle_busy", i), 32'(busy), 32'd0);
            chk($sformatf("vec%0d_idle_gnt", i), 32'(gnt), 32'd0);
            if (i == 4) begin
                // Late completion after a timeout must be ignored.
                q_enq_done = 1'b1;
                @(negedge clk);
                q_enq_done = 1'b0;
                repeat (2) begin
                    @(negedge clk);
                    chk("late_done_gnt", 32'(gnt), 32'd0);
                    chk("late_done_busy", 32'(busy), 32'd0);
                end
            end
        end

        // Fairness: all clients keep an enqueue pending, zero-wait queue.
        do_reset();
        q_empty = 1'b0;
        req_enq = '1;
        rer     = '0;
        for (int n = 0; n < 80 && order.size() < 5; n++) begin
            @(negedge clk);
            req_enq    = req_enq | rer;
            rer        = '0;
            q_enq_done = q_enq;
            if (gnt != '0) begin
                for (int i = 0; i < N; i++) if (gnt[i]) order.push_back(i);
                rer     = gnt;
                req_enq = req_enq & ~gnt;
            end
        end
        q_enq_done = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("fair_order%0d", k), 32'((k < order.size()) ? order[k] : 99),
                32'(k % 4));
        end

        // Client 3 asks for both: enqueue first, then dequeue; then reset mid-WAIT.
        do_reset();
        q_empty = 1'b0;
        set_key(3, 8'hC7);
        req_enq[3] = 1'b1;
        req_deq[3] = 1'b1;
        serve("both_enq", 1'b0, 1, 8'h00, 4'b1000, 1'b0, 8'h00, 3, 1, 8'hC7);
        serve("both_deq", 1'b1, 1, 8'h77, 4'b1000, 1'b0, 8'h77, 4, 1, 8'hC7);
        @(negedge clk);
        set_key(3, 8'hD1);
        req_enq[3] = 1'b1;
        seen = 1'b0;
        for (int n = 0; n < 10 && !seen; n++) begin
            @(negedge clk);
            if (q_enq) seen = 1'b1;
        end
        chk("midrst_strobe", 32'(seen), 32'd1);
        repeat (3) @(negedge clk);
        chk("midrst_busy_pre", 32'(busy), 32'd1);
        rst        = 1'b1;
        req_enq    = '0;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_gnt", 32'(gnt), 32'd0);
        chk("midrst_q_key", 32'(q_key), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("postrst_gnt", 32'(gnt), 32'd0);
            chk("postrst_busy", 32'(busy), 32'd0);
        end

        do_reset();
        random_phase(1500);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
